// File: rtl/dmem_lsu.sv
// Load/store unit between the execute stage and byte-addressed dmem.
// Word-crossing accesses are split into two word beats; bad requests complete with rsp_err and never write.
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   ACC0  | first (or only) word beat on the dmem port
//   ACC1  | second word beat of a word-crossing access
//   DONE  | one-cycle response pulse
module dmem_lsu #(
    parameter int unsigned MEM_BYTES      = 128,
    parameter bit          ALLOW_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic [31:0] drdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] acc_q;
    logic [31:0] rdata_q;

    logic [2:0]  req_size;
    logic [2:0]  req_last;
    logic [32:0] req_end;
    logic        req_legal;
    logic        req_err;

    logic [1:0]  off;
    logic [2:0]  size_q;
    logic [2:0]  last_q;
    logic        split;
    logic [3:0]  lane0;
    logic [3:0]  lane1;
    logic [4:0]  sh0;
    logic [5:0]  sh1;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] v;
        v = raw;
        case (f3)
            3'b000:  v = {{24{raw[7]}}, raw[7:0]};
            3'b001:  v = {{16{raw[15]}}, raw[15:0]};
            3'b100:  v = {24'd0, raw[7:0]};
            3'b101:  v = {16'd0, raw[15:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

    // 33-bit end address so a request wrapping past 2^32 is seen as out of range
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                    (!req_we && ((req_funct3 == 3'b100) || (req_funct3 == 3'b101)));
        req_last  = {1'b0, req_addr[1:0]} + req_size - 3'd1;
        req_end   = {1'b0, req_addr} + {30'd0, req_size} - 33'd1;
        req_err   = !req_legal || ((req_last > 3'd3) && !ALLOW_MISALIGN) ||
                    (req_end >= 33'(MEM_BYTES));
    end

    always_comb begin
        off = addr_q[1:0];
        case (f3_q[1:0])
            2'b00:   size_q = 3'd1;
            2'b01:   size_q = 3'd2;
            default: size_q = 3'd4;
        endcase
        last_q = {1'b0, off} + size_q - 3'd1;
        split  = last_q > 3'd3;
        sh0    = {off, 3'b000};
        sh1    = 6'd32 - {1'b0, off, 3'b000};
        lane0  = 4'd0;
        lane1  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            lane0[i] = (3'(i) >= {1'b0, off}) && (3'(i) <= last_q);
            lane1[i] = (3'(i) + 3'd4) <= last_q;
        end
    end

    // Outputs are decoded from registered state; all of them are forced low while rst_n is low.
    always_comb begin
        req_ready = (state == IDLE) && rst_n;
        daddr     = 32'd0;
        dwdata    = 32'd0;
        dwe       = 4'd0;
        if (rst_n && state == ACC0) begin
            daddr  = {addr_q[31:2], 2'b00};
            dwdata = wdata_q << sh0;
            dwe    = we_q ? lane0 : 4'd0;
        end else if (rst_n && state == ACC1) begin
            daddr  = {addr_q[31:2], 2'b00} + 32'd4;
            dwdata = wdata_q >> sh1;
            dwe    = we_q ? lane1 : 4'd0;
        end
        rsp_valid = rst_n && (state == DONE);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            acc_q   <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        acc_q   <= 32'd0;
                        rdata_q <= 32'd0;
                        state   <= req_err ? DONE : ACC0;
                    end
                end
                ACC0: begin
                    acc_q <= drdata >> sh0;
                    if (split) begin
                        state <= ACC1;
                    end else begin
                        rdata_q <= we_q ? 32'd0 : extend(f3_q, drdata >> sh0);
                        state   <= DONE;
                    end
                end
                ACC1: begin
                    // upper bytes above the access size are dropped by the extension
                    rdata_q <= we_q ? 32'd0 : extend(f3_q, acc_q | (drdata << sh1));
                    state   <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed table, reset-in-split sequence and random requests against a byte-level model.
// Instance a allows misaligned splits, instance b rejects them.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_valid_a, req_valid_b;

    logic        ready_a, valid_a, err_a;
    logic        ready_b, valid_b, err_b;
    logic [31:0] rdata_a, daddr_a, dwdata_a, drdata_a;
    logic [31:0] rdata_b, daddr_b, dwdata_b, drdata_b;
    logic [3:0]  dwe_a, dwe_b;

    bit [7:0] dmem    [2][128];
    bit [7:0] ref_mem [2][128];

    int nvec = 0;
    int nbad = 0;

    logic        sel = 1'b0;
    logic        m_ready, m_valid, m_err;
    logic [31:0] m_rdata, m_daddr, m_dwdata;
    logic [3:0]  m_dwe;

    dmem_lsu #(.MEM_BYTES(128), .ALLOW_MISALIGN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(ready_a),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(valid_a), .rsp_rdata(rdata_a), .rsp_err(err_a),
        .daddr(daddr_a), .dwdata(dwdata_a), .dwe(dwe_a), .drdata(drdata_a)
    );

    dmem_lsu #(.MEM_BYTES(128), .ALLOW_MISALIGN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(ready_b),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(valid_b), .rsp_rdata(rdata_b), .rsp_err(err_b),
        .daddr(daddr_b), .dwdata(dwdata_b), .dwe(dwe_b), .drdata(drdata_b)
    );

    assign drdata_a = {dmem[0][{daddr_a[6:2], 2'd3}], dmem[0][{daddr_a[6:2], 2'd2}],
                       dmem[0][{daddr_a[6:2], 2'd1}], dmem[0][{daddr_a[6:2], 2'd0}]};
    assign drdata_b = {dmem[1][{daddr_b[6:2], 2'd3}], dmem[1][{daddr_b[6:2], 2'd2}],
                       dmem[1][{daddr_b[6:2], 2'd1}], dmem[1][{daddr_b[6:2], 2'd0}]};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (dwe_a[i]) dmem[0][{daddr_a[6:2], 2'(i)}] <= dwdata_a[8*i +: 8];
            if (dwe_b[i]) dmem[1][{daddr_b[6:2], 2'(i)}] <= dwdata_b[8*i +: 8];
        end
    end

    assign m_ready  = sel ? ready_b  : ready_a;
    assign m_valid  = sel ? valid_b  : valid_a;
    assign m_err    = sel ? err_b    : err_a;
    assign m_rdata  = sel ? rdata_b  : rdata_a;
    assign m_daddr  = sel ? daddr_b  : daddr_a;
    assign m_dwdata = sel ? dwdata_b : dwdata_a;
    assign m_dwe    = sel ? dwe_b    : dwe_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic mem_chk(input logic s);
        int diffs = 0;
        for (int i = 0; i < 128; i++)
            if (dmem[s][i] != ref_mem[s][i]) diffs++;
        chk("mem_contents", 32'(diffs), 32'd0);
    endtask

    // Byte-level reference: legality, range, latency, then apply the access to ref_mem.
    task automatic model(input logic s, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic err, output int lat,
                         output logic [31:0] rdata);
        int     size;
        logic   legal;
        logic   split;
        longint last_byte;
        logic [31:0] v;
        legal = 1'b1;
        size  = 4;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    legal = 1'b0;
        endcase
        if (we && f3 >= 3'd4) legal = 1'b0;
        split     = (int'(addr % 4) + size) > 4;
        last_byte = longint'(addr) + longint'(size) - 1;
        err   = !legal || (split && s) || (last_byte >= 128);
        lat   = err ? 1 : (split ? 3 : 2);
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < size; k++) ref_mem[s][addr[6:0] + 7'(k)] = wdata[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < size; k++) v[8*k +: 8] = ref_mem[s][addr[6:0] + 7'(k)];
                if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
                if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
                rdata = v;
            end
        end
    endtask

    task automatic run(input logic s, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic e_err, output int e_lat,
                       output logic [31:0] e_rdata, output logic g_err, output int g_lat,
                       output logic [31:0] g_rdata);
        logic [31:0] bd [2];
        logic [3:0]  bw [2];
        logic [31:0] bdat [2];
        int          nb;
        int          size;
        logic [31:0] wb, a, emask_w, edat;
        logic [3:0]  emask;
        model(s, we, f3, addr, wdata, e_err, e_lat, e_rdata);
        sel        = s;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid_a = !s;
        req_valid_b = s;
        chk("ready_idle", 32'(m_ready), 32'd1);
        @(posedge clk); #1;
        g_lat = 1;
        nb    = 0;
        while (!m_valid && g_lat < 6) begin
            if (nb < 2) begin
                bd[nb]   = m_daddr;
                bw[nb]   = m_dwe;
                bdat[nb] = m_dwdata;
            end
            nb++;
            chk("ready_busy", 32'(m_ready), 32'd0);
            @(posedge clk); #1;
            g_lat++;
        end
        if (!m_valid) chk("rsp_timeout", 32'(m_valid), 32'd1);
        g_err   = m_err;
        g_rdata = m_rdata;
        chk("ready_done", 32'(m_ready), 32'd0);
        chk("dwe_done", 32'(m_dwe), 32'd0);
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        @(posedge clk); #1;
        size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        for (int b = 0; b < 2 && b < nb; b++) begin
            wb      = {addr[31:2], 2'b00} + 32'(4 * b);
            emask   = 4'd0;
            emask_w = 32'd0;
            edat    = 32'd0;
            for (int k = 0; k < size; k++) begin
                a = addr + 32'(k);
                if ({a[31:2], 2'b00} == wb && we) begin
                    emask[a[1:0]]            = 1'b1;
                    emask_w[8*a[1:0] +: 8]   = 8'hFF;
                    edat[8*a[1:0] +: 8]      = wdata[8*k +: 8];
                end
            end
            chk("beat_daddr", bd[b], wb);
            chk("beat_dwe", 32'(bw[b]), 32'(emask));
            chk("beat_lanes", bdat[b] & emask_w, edat);
        end
        mem_chk(s);
    endtask

    typedef struct {
        logic        s;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic        e_err, g_err;
        int          e_lat, g_lat;
        logic [31:0] e_rdata, g_rdata;
        logic        s, we;
        logic [2:0]  f3;
        logic [31:0] addr;

        tbl[0]  = '{1'b0, 1'b1, 3'd2, 32'h10,       32'hDEADBEEF, 1'b0, 2, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 3'd2, 32'h10,       32'h0,        1'b0, 2, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 3'd0, 32'h13,       32'h80,       1'b0, 2, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 32'h13,       32'h0,        1'b0, 2, 32'hFFFFFF80};
        tbl[4]  = '{1'b0, 1'b0, 3'd4, 32'h13,       32'h0,        1'b0, 2, 32'h00000080};
        tbl[5]  = '{1'b0, 1'b1, 3'd2, 32'h0E,       32'h11223344, 1'b0, 3, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 3'd2, 32'h0E,       32'h0,        1'b0, 3, 32'h11223344};
        tbl[7]  = '{1'b0, 1'b0, 3'd1, 32'h0F,       32'h0,        1'b0, 3, 32'h00002233};
        tbl[8]  = '{1'b0, 1'b1, 3'd1, 32'h7F,       32'h0000BEEF, 1'b1, 1, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 3'd4, 32'h20,       32'h000000AA, 1'b1, 1, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 3'd3, 32'h20,       32'h0,        1'b1, 1, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 3'd2, 32'hFFFFFFFE, 32'h0,        1'b1, 1, 32'h0};
        tbl[12] = '{1'b1, 1'b1, 3'd1, 32'h02,       32'h00008001, 1'b0, 2, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 3'd1, 32'h02,       32'h0,        1'b0, 2, 32'hFFFF8001};
        tbl[14] = '{1'b1, 1'b0, 3'd2, 32'h02,       32'h0,        1'b1, 1, 32'h0};
        tbl[15] = '{1'b1, 1'b1, 3'd2, 32'h0E,       32'h12345678, 1'b1, 1, 32'h0};

        rst_n       = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_we      = 1'b0;
        req_funct3  = 3'd0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_dwe", 32'(dwe_a), 32'd0);
        chk("rst_daddr", daddr_a, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(ready_a), 32'd1);
        chk("rel_ready_b", 32'(ready_b), 32'd1);
        chk("rel_rdata", rdata_a, 32'd0);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            run(tbl[i].s, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                e_err, e_lat, e_rdata, g_err, g_lat, g_rdata);
            chk($sformatf("tbl%0d_err", i), 32'(g_err), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_lat", i), 32'(g_lat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d_rdata", i), g_rdata, tbl[i].rdata);
        end

        // reset while the second beat of a split store is on the port
        sel         = 1'b0;
        req_we      = 1'b1;
        req_funct3  = 3'd2;
        req_addr    = 32'h0E;
        req_wdata   = 32'hAABBCCDD;
        req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        @(posedge clk); #1;
        chk("split_acc1_dwe", 32'(dwe_a), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("midrst_dwe", 32'(dwe_a), 32'd0);
        chk("midrst_valid", 32'(valid_a), 32'd0);
        @(posedge clk); #1;
        chk("midrst_valid_after", 32'(valid_a), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready_a), 32'd1);
        ref_mem[0][14] = 8'hDD;
        ref_mem[0][15] = 8'hCC;
        @(posedge clk); #1;
        chk("midrst_no_rsp", 32'(valid_a), 32'd0);
        mem_chk(1'b0);

        for (int n = 0; n < 400; n++) begin
            s    = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 131));
            run(s, we, f3, addr, $urandom, e_err, e_lat, e_rdata, g_err, g_lat, g_rdata);
            chk("rnd_err", 32'(g_err), 32'(e_err));
            chk("rnd_lat", 32'(g_lat), 32'(e_lat));
            chk("rnd_rdata", g_rdata, e_rdata);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
